// File: rtl/cond_branch_pc_if.sv
// ---------------------------------------------------------------------------
// cond_branch_pc_if
// Instruction-fetch / register-file side bundle for the branch sequencer.
//   instr        8   instruction byte at the current PC
//   instr_valid  1   instr is valid this cycle
//   instr_ready  1   sequencer accepts instr this cycle
//   reg0         8   jump target address, sampled at accept
//   reg3         8   condition operand (two's complement), sampled at accept
// master = fetch/register-file side, slave = the sequencer.
// ---------------------------------------------------------------------------
interface cond_branch_pc_if;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] reg0;
    logic [7:0] reg3;

    modport master (
        output instr,
        output instr_valid,
        output reg0,
        output reg3,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_valid,
        input  reg0,
        input  reg3,
        output instr_ready
    );
endinterface

// File: rtl/cond_branch_pc.sv
// ---------------------------------------------------------------------------
// cond_branch_pc
// Program counter and conditional-jump sequencer for the 8-bit core.
// Sequential instructions advance the PC by one. Conditional jumps
// (instr[7:6] == 2'b11) latch the condition code, operand and target,
// evaluate the condition one cycle later and commit either the target or
// PC+1 in the cycle after that.
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   en           global step enable, 0 freezes all state
//   bus          instruction / register handshake (slave modport)
//   pc           current program counter
//   cond_code    condition code of the last accepted jump
//   branch_busy  high while evaluating or committing a jump
//   taken_pulse  one-cycle pulse when the PC is loaded with a jump target
//   taken_cnt    saturating count of taken jumps
// ---------------------------------------------------------------------------
module cond_branch_pc #(
    parameter logic [7:0] RESET_PC = 8'd0,
    parameter int         CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    cond_branch_pc_if.slave    bus,
    output logic [7:0]         pc,
    output logic [2:0]         cond_code,
    output logic               branch_busy,
    output logic               taken_pulse,
    output logic [CNT_W-1:0]   taken_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] opnd;
    logic [7:0] tgt;
    logic       taken;
    logic       pulse_q;
    logic       is_jump;
    logic       accept;
    logic       cond_true;
    logic       opnd_z;
    logic       opnd_n;

    // Decode the instruction class, qualify the handshake and evaluate the
    // latched condition against the latched operand.
    always_comb begin
        is_jump   = (bus.instr[7:6] == 2'b11);
        accept    = (state == RUN) && bus.instr_valid && en;
        opnd_z    = (opnd == 8'h00);
        opnd_n    = opnd[7];
        cond_true = 1'b0;
        unique case (cond_code)
            3'd0:    cond_true = 1'b0;
            3'd1:    cond_true = opnd_z;
            3'd2:    cond_true = opnd_n;
            3'd3:    cond_true = opnd_z | opnd_n;
            3'd4:    cond_true = 1'b1;
            3'd5:    cond_true = ~opnd_z;
            3'd6:    cond_true = ~opnd_n;
            default: cond_true = ~opnd_z & ~opnd_n;
        endcase
    end

    // Next-state logic. Nothing moves while en is low; a jump always walks
    // RUN -> EVAL -> COMMIT -> RUN.
    always_comb begin
        state_next = state;
        if (en) begin
            unique case (state)
                RUN:     if (accept && is_jump) state_next = EVAL;
                EVAL:    state_next = COMMIT;
                COMMIT:  state_next = RUN;
                default: state_next = RUN;
            endcase
        end
    end

    // State register. Reset wins over en and drops any in-flight jump.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: PC, latched jump context, taken flag, pulse and counter.
    // The pulse register is cleared while disabled so a pulse can never
    // reappear after en returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            cond_code <= 3'd0;
            opnd      <= 8'h00;
            tgt       <= 8'h00;
            taken     <= 1'b0;
            pulse_q   <= 1'b0;
            taken_cnt <= '0;
        end else if (!en) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            unique case (state)
                RUN: begin
                    if (accept) begin
                        if (is_jump) begin
                            cond_code <= bus.instr[2:0];
                            opnd      <= bus.reg3;
                            tgt       <= bus.reg0;
                        end else begin
                            pc <= pc + 8'd1;
                        end
                    end
                end
                EVAL: begin
                    taken <= cond_true;
                end
                COMMIT: begin
                    if (taken) begin
                        pc      <= tgt;
                        pulse_q <= 1'b1;
                        if (taken_cnt != {CNT_W{1'b1}}) begin
                            taken_cnt <= taken_cnt + 1'b1;
                        end
                    end else begin
                        pc <= pc + 8'd1;
                    end
                end
                default: begin
                    pc <= pc;
                end
            endcase
        end
    end

    // Handshake and status outputs; the pulse is masked immediately by en.
    always_comb begin
        bus.instr_ready = (state == RUN);
        branch_busy     = (state != RUN);
        taken_pulse     = pulse_q & en;
    end

endmodule

// File: tb/tb_cond_branch_pc.sv
// ---------------------------------------------------------------------------
// tb_cond_branch_pc
// Directed self-checking bench for cond_branch_pc: reset, sequential
// stepping, jump latency, full condition sweep, PC wrap, reset during a
// jump, enable freeze, operand latching and counter saturation.
// ---------------------------------------------------------------------------
module tb_cond_branch_pc;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] pc;
    logic [2:0] cond_code;
    logic       branch_busy;
    logic       taken_pulse;
    logic [7:0] taken_cnt;

    int numChecks = 0;
    int numPassed = 0;
    int numFailed = 0;

    logic [7:0] expPc;
    int         expCnt;

    cond_branch_pc_if bus ();

    cond_branch_pc #(
        .RESET_PC (8'd0),
        .CNT_W    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .bus         (bus.slave),
        .pc          (pc),
        .cond_code   (cond_code),
        .branch_busy (branch_busy),
        .taken_pulse (taken_pulse),
        .taken_cnt   (taken_cnt)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            numPassed++;
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference condition table.
    function automatic logic refTaken(input logic [2:0] c, input logic [7:0] op);
        logic z;
        logic n;
        z = (op == 8'h00);
        n = op[7];
        case (c)
            3'd0:    return 1'b0;
            3'd1:    return z;
            3'd2:    return n;
            3'd3:    return z || n;
            3'd4:    return 1'b1;
            3'd5:    return !z;
            3'd6:    return !n;
            default: return !z && !n;
        endcase
    endfunction

    // Present one instruction, wait (bounded) for acceptance, and for a jump
    // run through EVAL and COMMIT so the caller sees the committed PC.
    task automatic applyStimulus(input logic [7:0] ins, input logic [7:0] r0, input logic [7:0] r3);
        int waitCnt;
        bus.instr       = ins;
        bus.reg0        = r0;
        bus.reg3        = r3;
        bus.instr_valid = 1'b1;
        waitCnt = 0;
        while (!bus.instr_ready && waitCnt < 10) begin
            step();
            waitCnt++;
        end
        if (!bus.instr_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
        step();
        bus.instr_valid = 1'b0;
        if (ins[7:6] == 2'b11) begin
            step();
            step();
        end
    endtask

    task automatic runSeq();
        applyStimulus(8'h00, 8'h00, 8'h00);
        expPc = expPc + 8'd1;
        checkOutput("seq_pc", pc, expPc);
    endtask

    task automatic runJump(input logic [2:0] c, input logic [7:0] target, input logic [7:0] op);
        logic tk;
        tk = refTaken(c, op);
        applyStimulus({5'b11000, c}, target, op);
        expPc = tk ? target : expPc + 8'd1;
        if (tk && expCnt < 255) expCnt++;
        checkOutput("jump_pc", pc, expPc);
        checkOutput("jump_pulse", taken_pulse, tk);
        checkOutput("jump_cnt", taken_cnt, expCnt);
    endtask

    initial begin
        logic [7:0] ops [3];
        ops[0] = 8'h00;
        ops[1] = 8'h05;
        ops[2] = 8'h80;

        bus.instr       = 8'h00;
        bus.instr_valid = 1'b0;
        bus.reg0        = 8'h00;
        bus.reg3        = 8'h00;
        en              = 1'b1;
        rst             = 1'b1;
        expPc           = 8'h00;
        expCnt          = 0;

        // Reset state, then three sequential instructions.
        step();
        rst = 1'b0;
        checkOutput("rst_pc", pc, 8'h00);
        checkOutput("rst_cnt", taken_cnt, 0);
        checkOutput("rst_busy", branch_busy, 0);
        checkOutput("rst_pulse", taken_pulse, 0);
        checkOutput("rst_cond", cond_code, 0);
        checkOutput("rst_ready", bus.instr_ready, 1);
        repeat (3) runSeq();
        checkOutput("seq_cnt", taken_cnt, 0);

        // Reset while in EVAL.
        bus.instr = 8'hC4; bus.reg0 = 8'h55; bus.reg3 = 8'h00; bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        expPc = 8'h00;
        checkOutput("rstEval_pc", pc, 8'h00);
        checkOutput("rstEval_busy", branch_busy, 0);
        checkOutput("rstEval_ready", bus.instr_ready, 1);
        checkOutput("rstEval_pulse", taken_pulse, 0);
        checkOutput("rstEval_cnt", taken_cnt, 0);

        // Reset while in COMMIT.
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("rstCommit_pc", pc, 8'h00);
        checkOutput("rstCommit_busy", branch_busy, 0);
        checkOutput("rstCommit_pulse", taken_pulse, 0);
        checkOutput("rstCommit_cnt", taken_cnt, 0);
        step();
        checkOutput("rstCommit_pc_hold", pc, 8'h00);

        // Walk to 0x10, then an always-taken jump with cycle-level checks.
        repeat (16) runSeq();
        checkOutput("walk_pc", pc, 8'h10);
        bus.instr = 8'hC4; bus.reg0 = 8'h40; bus.reg3 = 8'h33; bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        checkOutput("lat_busy1", branch_busy, 1);
        checkOutput("lat_ready1", bus.instr_ready, 0);
        checkOutput("lat_pc1", pc, 8'h10);
        checkOutput("lat_cond", cond_code, 3'd4);
        step();
        checkOutput("lat_busy2", branch_busy, 1);
        checkOutput("lat_pc2", pc, 8'h10);
        step();
        checkOutput("lat_pc3", pc, 8'h40);
        checkOutput("lat_pulse3", taken_pulse, 1);
        checkOutput("lat_busy3", branch_busy, 0);
        checkOutput("lat_cnt3", taken_cnt, 1);
        step();
        checkOutput("lat_pulse4", taken_pulse, 0);
        checkOutput("lat_pc4", pc, 8'h40);
        expPc  = 8'h40;
        expCnt = 1;

        // Condition sweep over all codes and three operand classes.
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 3; k++) begin
                runJump(c[2:0], 8'h80 + 8'(c * 4 + k), ops[k]);
                checkOutput("sweep_cond", cond_code, c);
            end
        end

        // PC wrap via sequential and via a not-taken jump.
        runJump(3'd4, 8'hFF, 8'h00);
        runSeq();
        checkOutput("wrap_seq", pc, 8'h00);
        runJump(3'd4, 8'hFF, 8'h00);
        runJump(3'd0, 8'h12, 8'h00);
        checkOutput("wrap_jump", pc, 8'h00);

        // Jump to the current PC is legal.
        runJump(3'd4, 8'h00, 8'h00);
        checkOutput("self_jump", pc, 8'h00);

        // Freeze mid-branch; reg0/reg3 change after accept and a sequential
        // instruction is held valid while busy, none of which may matter.
        bus.instr = 8'hC6; bus.reg0 = 8'h77; bus.reg3 = 8'h05; bus.instr_valid = 1'b1;
        step();
        bus.instr = 8'h00; bus.reg0 = 8'h99; bus.reg3 = 8'h80;
        en = 1'b0;
        repeat (5) step();
        checkOutput("frz_busy", branch_busy, 1);
        checkOutput("frz_ready", bus.instr_ready, 0);
        checkOutput("frz_pc", pc, expPc);
        checkOutput("frz_cnt", taken_cnt, expCnt);
        en = 1'b1;
        step();
        checkOutput("frz_busy_eval", branch_busy, 1);
        checkOutput("frz_pc_eval", pc, expPc);
        step();
        bus.instr_valid = 1'b0;
        expPc = 8'h77;
        expCnt++;
        checkOutput("frz_pc_commit", pc, 8'h77);
        checkOutput("frz_pulse", taken_pulse, 1);
        checkOutput("frz_cnt_commit", taken_cnt, expCnt);
        en = 1'b0;
        #1;
        checkOutput("en_pulse_mask", taken_pulse, 0);
        step();
        checkOutput("en_pc_hold", pc, 8'h77);
        en = 1'b1;
        #1;
        checkOutput("en_pulse_cleared", taken_pulse, 0);
        step();
        checkOutput("en_pc_idle", pc, 8'h77);

        // Drive the counter to saturation and one past it.
        while (expCnt < 255) runJump(3'd4, 8'h30, 8'h00);
        checkOutput("sat_full", taken_cnt, 255);
        runJump(3'd4, 8'h31, 8'h00);
        checkOutput("sat_hold", taken_cnt, 255);

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule
